uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter that wraps each accepted payload byte in a 4-byte frame
// (sync, source id, payload, xor check) and feeds it to a UART byte transmitter.
module uart_tx_arbiter #(
    parameter logic [7:0] SYNC_BYTE  = 8'hAA,
    parameter int         TMO_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy,
    output logic       grant_id,
    output logic [7:0] frames_sent,
    output logic       tmo_err,
    output logic [1:0] state_dbg
);

    // Handshake: a payload moves when reqN_valid and reqN_ready are both high at
    // a rising clk edge; ready is offered only in IDLE and only to the granted
    // requester, and valid/data must stay stable until that edge.

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

    state_t     state;
    logic [1:0] idx;
    logic [7:0] payload;
    logic       src;
    logic       last_grant;
    logic [7:0] tmo_cnt;

    logic       gnt_valid;
    logic       gnt_src;
    logic       accept;
    logic       tmo_hit;
    logic       byte_done;

    function automatic logic [7:0] frame_byte(input logic [1:0] i, input logic s,
                                              input logic [7:0] p);
        logic [7:0] b;
        case (i)
            2'd0:    b = SYNC_BYTE;
            2'd1:    b = {7'd0, s};
            2'd2:    b = p;
            default: b = SYNC_BYTE ^ {7'd0, s} ^ p;
        endcase
        return b;
    endfunction

    // Round-robin: on a tie the requester that was not granted last wins.
    always_comb begin
        gnt_valid = req0_valid | req1_valid;
        gnt_src   = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_src = ~last_grant;
        end else if (req1_valid) begin
            gnt_src = 1'b1;
        end
    end

    assign req0_ready = (state == IDLE) && !rst && gnt_valid && !gnt_src;
    assign req1_ready = (state == IDLE) && !rst && gnt_valid && gnt_src;
    assign accept     = req0_ready | req1_ready;

    // A byte whose busy never showed up is treated as finished once the window expires.
    assign tmo_hit   = (state == WAIT_BUSY) && !tx_busy && (tmo_cnt == TMO_LAST);
    assign byte_done = tmo_hit || ((state == WAIT_DONE) && !tx_busy);

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 2'd0;
            payload     <= 8'h00;
            src         <= 1'b0;
            last_grant  <= 1'b1;
            tmo_cnt     <= 8'd0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            grant_id    <= 1'b0;
            frames_sent <= 8'd0;
            tmo_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_start <= 1'b0;
                    if (accept) begin
                        payload    <= gnt_src ? req1_data : req0_data;
                        src        <= gnt_src;
                        last_grant <= gnt_src;
                        grant_id   <= gnt_src;
                        idx        <= 2'd0;
                        tx_data    <= SYNC_BYTE;
                        tx_start   <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    tx_start <= 1'b0;
                    tmo_cnt  <= 8'd0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY, WAIT_DONE: begin
                    if (state == WAIT_BUSY) begin
                        if (tx_busy) begin
                            state <= WAIT_DONE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 8'd1;
                            if (tmo_hit) begin
                                tmo_err <= 1'b1;
                            end
                        end
                    end
                    if (byte_done) begin
                        if (idx == 2'd3) begin
                            frames_sent <= frames_sent + 8'd1;
                            state       <= IDLE;
                        end else begin
                            idx      <= idx + 2'd1;
                            tx_data  <= frame_byte(idx + 2'd1, src, payload);
                            tx_start <= 1'b1;
                            state    <= START;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: requester queues, a transmitter model with
// random busy timing, and a frame-level reference model feeding an expected byte queue.
module tb_uart_tx_arbiter;

    localparam logic [7:0] SYNC = 8'hAA;
    localparam int         TMO  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy = 1'b0;
    logic       busy;
    logic       grant_id;
    logic [7:0] frames_sent;
    logic       tmo_err;
    logic [1:0] state_dbg;

    uart_tx_arbiter #(.SYNC_BYTE(SYNC), .TMO_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .busy(busy), .grant_id(grant_id), .frames_sent(frames_sent),
        .tmo_err(tmo_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // requester queues and scoreboard
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] exp_q[$];
    logic       exp_src_q[$];
    logic       m_last = 1'b1;
    logic [7:0] exp_frames = 8'd0;
    int         fires0 = 0;
    int         fires1 = 0;
    int         started = 0;
    logic       cur_src = 1'b0;
    logic       prev_start = 1'b0;
    bit         f0 = 0;
    bit         f1 = 0;

    // transmitter model knobs/state
    bit tmo_mode = 0;
    int dly_hi = 3;
    int len_lo = 1;
    int len_hi = 12;
    bit pend = 0;
    int dly = 0;
    int len_cnt = 0;
    bit saw_start = 0;

    // monitor: samples on the falling edge
    always @(negedge clk) begin
        f0 = req0_valid && req0_ready;
        f1 = req1_valid && req1_ready;
        saw_start = tx_start;
        if (rst) begin
            check("ready_in_rst", {30'd0, req0_ready, req1_ready}, 32'd0);
            started    = 0;
            prev_start = 1'b0;
        end else begin
            if (f0 || f1) begin
                fires0 += int'(f0);
                fires1 += int'(f1);
                if (exp_src_q.size() == 0) begin
                    check("unexpected_grant", {30'd0, f0, f1}, 32'd0);
                end else begin
                    cur_src = exp_src_q.pop_front();
                    check("grant_src", {31'd0, f1}, {31'd0, cur_src});
                end
            end
            if (tx_start) begin
                check("start_while_busy", {31'd0, tx_busy}, 32'd0);
                check("start_width", {31'd0, prev_start}, 32'd0);
                if (exp_q.size() == 0) check("extra_start", {24'd0, tx_data}, 32'hFFFF_FFFF);
                else check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                if (started % 4 == 1) check("grant_id", {31'd0, grant_id}, {31'd0, cur_src});
                started++;
            end
            prev_start = tx_start;
        end
    end

    // drivers: requesters and transmitter, updated just after the rising edge
    always @(posedge clk) begin
        #1;
        if (f0 && q0.size() > 0) q0.delete(0);
        if (f1 && q1.size() > 0) q1.delete(0);
        f0 = 0;
        f1 = 0;
        req0_valid = (q0.size() > 0);
        req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
        req1_valid = (q1.size() > 0);
        req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
        if (rst) begin
            tx_busy = 1'b0;
            pend    = 0;
        end else begin
            if (saw_start && !tmo_mode) begin
                pend = 1;
                dly  = $urandom_range(dly_hi, 0);
            end
            if (tx_busy) begin
                if (len_cnt <= 1) tx_busy = 1'b0;
                else len_cnt--;
            end else if (pend) begin
                if (dly == 0) begin
                    tx_busy = 1'b1;
                    pend    = 0;
                    len_cnt = $urandom_range(len_hi, len_lo);
                end else begin
                    dly--;
                end
            end
        end
        saw_start = 0;
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_src_q.delete();
        m_last     = 1'b1;
        exp_frames = 8'd0;
        fires0     = 0;
        fires1     = 0;
        cur_src    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant_id", {31'd0, grant_id}, 32'd0);
        check("rst_frames", {24'd0, frames_sent}, 32'd0);
        check("rst_tmo_err", {31'd0, tmo_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // reference model: frame order follows from the queues alone
    task automatic plan(input int n0, input int n1);
        logic [7:0] a[$];
        logic [7:0] b[$];
        logic [7:0] d;
        logic [7:0] sb;
        logic       s;
        for (int i = 0; i < n0; i++) begin
            d = 8'($urandom);
            a.push_back(d);
            q0.push_back(d);
        end
        for (int i = 0; i < n1; i++) begin
            d = 8'($urandom);
            b.push_back(d);
            q1.push_back(d);
        end
        while (a.size() > 0 || b.size() > 0) begin
            if (a.size() > 0 && b.size() > 0) s = ~m_last;
            else s = (a.size() == 0);
            if (s) begin d = b[0]; b.delete(0); end
            else begin d = a[0]; a.delete(0); end
            sb = {7'd0, s};
            exp_q.push_back(SYNC);
            exp_q.push_back(sb);
            exp_q.push_back(d);
            exp_q.push_back(SYNC ^ sb ^ d);
            exp_src_q.push_back(s);
            m_last = s;
            exp_frames++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        bit done;
        n    = 0;
        done = 0;
        while (!done && n < 10000) begin
            @(negedge clk);
            #1;
            n++;
            done = (exp_q.size() == 0) && (q0.size() == 0) && (q1.size() == 0)
                   && !busy && !tx_busy && !pend;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int n;
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        do_reset();

        // single request, fixed 10-cycle busy
        len_lo = 10;
        len_hi = 10;
        q0.push_back(8'h03);
        exp_q = '{8'hAA, 8'h00, 8'h03, 8'hA9};
        exp_src_q.push_back(1'b0);
        m_last = 1'b0;
        exp_frames = 8'd1;
        wait_idle("single");
        check("single_frames", {24'd0, frames_sent}, 32'd1);
        check("single_grant", {31'd0, grant_id}, 32'd0);
        check("single_ready0", fires0, 1);

        // simultaneous requests after reset
        do_reset();
        q0.push_back(8'h01);
        q1.push_back(8'h7F);
        exp_q = '{8'hAA, 8'h00, 8'h01, 8'hAB, 8'hAA, 8'h01, 8'h7F, 8'hD4};
        exp_src_q.push_back(1'b0);
        exp_src_q.push_back(1'b1);
        m_last = 1'b1;
        exp_frames = 8'd2;
        wait_idle("simul");
        check("simul_frames", {24'd0, frames_sent}, 32'd2);
        check("simul_ready0", fires0, 1);
        check("simul_ready1", fires1, 1);

        // round-robin fairness with random timing
        len_lo = 1;
        len_hi = 12;
        do_reset();
        plan(3, 3);
        wait_idle("rr");
        check("rr_frames", {24'd0, frames_sent}, 32'd6);
        check("rr_ready0", fires0, 3);
        check("rr_ready1", fires1, 3);

        for (int k = 0; k < 5; k++) begin
            plan($urandom_range(4, 0), $urandom_range(4, 0));
            wait_idle("rand");
            check("rand_frames", {24'd0, frames_sent}, {24'd0, exp_frames});
        end
        check("no_tmo", {31'd0, tmo_err}, 32'd0);

        // timeout: transmitter never answers
        do_reset();
        tmo_mode = 1;
        plan(1, 0);
        n = 0;
        @(negedge clk);
        while (!tx_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_first_start", {31'd0, tx_start}, 32'd1);
        n = 0;
        while (!tmo_err && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_latency", n, TMO + 1);
        wait_idle("tmo");
        check("tmo_err", {31'd0, tmo_err}, 32'd1);
        check("tmo_frames", {24'd0, frames_sent}, 32'd1);
        tmo_mode = 0;
        plan(0, 1);
        wait_idle("tmo_sticky");
        check("tmo_sticky", {31'd0, tmo_err}, 32'd1);
        check("tmo_frames2", {24'd0, frames_sent}, 32'd2);

        // reset during WAIT_DONE of byte 2
        do_reset();
        len_lo = 10;
        len_hi = 10;
        q0.push_back(8'h55);
        q1.push_back(8'h66);
        exp_q = '{8'hAA, 8'h00, 8'h55, 8'hFF};
        exp_src_q.push_back(1'b0);
        n = 0;
        while (!(started == 3 && tx_busy) && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        check("mid_reach", {31'd0, busy}, 32'd1);
        do_reset();
        exp_q = '{8'hAA, 8'h01, 8'h66, 8'hCD};
        exp_src_q.push_back(1'b1);
        m_last = 1'b1;
        exp_frames = 8'd1;
        wait_idle("mid");
        check("mid_frames", {24'd0, frames_sent}, 32'd1);
        check("mid_ready0", fires0, 0);
        check("mid_ready1", fires1, 1);

        // frame counter wrap
        do_reset();
        dly_hi = 0;
        len_lo = 1;
        len_hi = 1;
        plan(128, 127);
        wait_idle("wrap255");
        check("frames_255", {24'd0, frames_sent}, 32'd255);
        plan(1, 0);
        wait_idle("wrap");
        check("frames_wrap", {24'd0, frames_sent}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
